// File: rtl/i2s_tdm_audio_tx.sv
// Audio serial transmitter: frame FIFO feeding an I2S (2 ch) or TDM (>2 ch) serialiser.
// Bit clock is derived from clk by SCLK_DIV; all serial outputs are registered.
module i2s_tdm_audio_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int CHANNELS   = 2,
    parameter int SCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             mute,
    input  logic                             sample_valid,
    output logic                             sample_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0]     sample_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             underrun,
    input  logic                             underrun_clr,
    output logic                             i2s_sclk,
    output logic                             i2s_lrclk,
    output logic                             i2s_sda
);
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam int N  = CHANNELS * SLOT_W;
    localparam int BW = $clog2(N);
    localparam int DW = $clog2(SCLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-1:0]  shift_q, shift_d, frame_bits, load_bits;
    logic          sclk_q, sclk_d, lrclk_q, lrclk_d, sda_q, sda_d;
    logic          underrun_q, underrun_d;
    logic          wr_en, pop, frame_start, bit_adv, stop;

    // lrclk leads the data by one bit so the MSB follows the lrclk edge
    function automatic logic lr_of(input logic [BW-1:0] b);
        if (CHANNELS == 2) return ((int'(b) + 1) % N) >= SLOT_W;
        else               return int'(b) == N - 1;
    endfunction

    assign sample_ready = !rst && (count_q != LW'(FIFO_DEPTH));
    assign wr_en        = sample_valid && sample_ready;
    assign fifo_level   = count_q;
    assign underrun     = underrun_q;
    assign i2s_sclk     = sclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sda      = sda_q;

    // Wire image of the head frame: slots in channel order, sample MSB first, zero pad
    always_comb begin
        frame_bits = '0;
        for (int c = 0; c < CHANNELS; c++)
            frame_bits[N-1-c*SLOT_W -: SAMPLE_W] = mem_q[rd_ptr_q][c*SAMPLE_W +: SAMPLE_W];
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        sclk_d      = sclk_q;
        lrclk_d     = lrclk_q;
        sda_d       = sda_q;
        underrun_d  = underrun_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        frame_start = 1'b0;
        bit_adv     = 1'b0;
        stop        = 1'b0;
        pop         = 1'b0;
        load_bits   = '0;

        case (state_q)
            IDLE: frame_start = enable;
            RUN: begin
                if (div_q == DW'(SCLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q)                   sclk_d = 1'b1;
                    else if (bit_q != BW'(N - 1))  bit_adv = 1'b1;
                    else if (enable)               frame_start = 1'b1;
                    else                           stop = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: stop = 1'b1;
        endcase

        if (underrun_clr) underrun_d = 1'b0;

        if (frame_start) begin
            pop       = (count_q != '0);
            load_bits = (pop && !mute) ? frame_bits : '0;
            state_d   = RUN;
            div_d     = '0;
            bit_d     = '0;
            sclk_d    = 1'b0;
            sda_d     = load_bits[N-1];
            shift_d   = load_bits << 1;
            lrclk_d   = lr_of('0);
            if (!pop) underrun_d = 1'b1;
        end else if (bit_adv) begin
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b0;
            sda_d   = shift_q[N-1];
            shift_d = shift_q << 1;
            lrclk_d = lr_of(bit_q + 1'b1);
        end else if (stop) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sda_d   = 1'b0;
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= sample_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sda_q      <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sda_q      <= sda_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_i2s_tdm_audio_tx.sv
// Bench for i2s_tdm_audio_tx: stereo I2S instance plus a 4-channel TDM instance,
// frames captured on rising sclk and compared with a bit-rule model.
module tb_i2s_tdm_audio_tx;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        en2 = 0, mute2 = 0, v2 = 0, clr2 = 0;
    logic [31:0] d2 = '0;
    logic        rdy2, ur2, sclk2, lr2, sda2;
    logic [4:0]  lvl2;

    logic        en4 = 0, mute4 = 0, v4 = 0, clr4 = 0;
    logic [63:0] d4 = '0;
    logic        rdy4, ur4, sclk4, lr4, sda4;
    logic [4:0]  lvl4;

    i2s_tdm_audio_tx dut2 (
        .clk(clk), .rst(rst), .enable(en2), .mute(mute2), .sample_valid(v2),
        .sample_ready(rdy2), .sample_data(d2), .fifo_level(lvl2), .underrun(ur2),
        .underrun_clr(clr2), .i2s_sclk(sclk2), .i2s_lrclk(lr2), .i2s_sda(sda2));

    i2s_tdm_audio_tx #(.SAMPLE_W(16), .SLOT_W(16), .CHANNELS(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .mute(mute4), .sample_valid(v4),
        .sample_ready(rdy4), .sample_data(d4), .fifo_level(lvl4), .underrun(ur4),
        .underrun_clr(clr4), .i2s_sclk(sclk4), .i2s_lrclk(lr4), .i2s_sda(sda4));

    bit   sel = 0;
    logic m_sclk, m_lr, m_sda;
    assign m_sclk = sel ? sclk4 : sclk2;
    assign m_lr   = sel ? lr4   : lr2;
    assign m_sda  = sel ? sda4  : sda2;

    int total = 0, bad = 0;
    logic [31:0] mq[$];

    typedef struct {
        logic [15:0] l, r;
        bit          mu;
        logic [63:0] exp_sda, exp_lr;
    } vec_t;
    vec_t tbl[4];

    task automatic tick(); @(negedge clk); endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    // Bit b of a frame: channel b/slot, position b%slot, sample MSB first, zero pad
    function automatic logic [63:0] exp_bits(input logic [63:0] d, input bit mu,
                                             input int slot, input int sw);
        logic [63:0] r = '0;
        for (int b = 0; b < 64; b++) begin
            int c = b / slot;
            int s = b % slot;
            if (s < sw && !mu) r[63-b] = d[c*sw + sw-1-s];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_lr(input int ch, input int slot);
        logic [63:0] r = '0;
        for (int b = 0; b < 64; b++)
            r[63-b] = (ch == 2) ? (((b + 1) % 64) >= slot) : (b == 63);
        return r;
    endfunction

    task automatic capture(input int stop_at, output logic [63:0] sw, output logic [63:0] lw);
        int b = 0, tmo = 0, cyc = 0, last = -1, pbad = 0;
        logic prev;
        sw = '0; lw = '0; prev = m_sclk;
        while (b < 64 && tmo < 200) begin
            @(negedge clk); cyc++; tmo++;
            if (!prev && m_sclk) begin
                sw[63-b] = m_sda; lw[63-b] = m_lr;
                if (last >= 0 && cyc - last != 8) pbad++;
                last = cyc; b++; tmo = 0;
                if (b - 1 == stop_at) begin
                    if (sel) en4 = 0; else en2 = 0;
                end
            end
            prev = m_sclk;
        end
        chk("frame_complete", 64'(b), 64'd64);
        chk("sclk_period", 64'(pbad), 64'd0);
    endtask

    task automatic wait_idle();
        int q = 0, t = 0;
        while (q < 12 && t < 2000) begin
            @(negedge clk); t++;
            if (!m_sclk && !m_lr && !m_sda) q++; else q = 0;
        end
        chk("idle_reached", 64'(q >= 12), 64'd1);
    endtask

    task automatic push(input logic [31:0] d);
        bit acc = (mq.size() < 16);
        chk("sample_ready", 64'(rdy2), 64'(acc));
        v2 = 1; d2 = d;
        tick();
        v2 = 0;
        if (acc) mq.push_back(d);
    endtask

    // Frames come from the model queue in order; an empty queue gives a zero frame
    task automatic play(input int nfr, input int stop_last, input bit mu);
        logic [63:0] sw, lw, ed;
        for (int f = 0; f < nfr; f++) begin
            ed = (mq.size() > 0) ? {32'h0, mq.pop_front()} : 64'h0;
            capture(f == nfr - 1 ? stop_last : -1, sw, lw);
            chk("frame_sda", sw, exp_bits(ed, mu, 32, 16));
            chk("frame_lrclk", lw, exp_lr(2, 32));
            chk("fifo_level", 64'(lvl2), 64'(mq.size()));
        end
        wait_idle();
    endtask

    task automatic chk_reset_state();
        chk("rst_sclk", 64'(sclk2), 0);
        chk("rst_lrclk", 64'(lr2), 0);
        chk("rst_sda", 64'(sda2), 0);
        chk("rst_underrun", 64'(ur2), 0);
        chk("rst_level", 64'(lvl2), 0);
        chk("rst_ready", 64'(rdy2), 1);
    endtask

    initial begin
        logic [63:0] sw, lw;
        int k;
        bit mu;

        tbl[0] = '{16'hA5F0, 16'h0F0F, 0, 64'hA5F0_0000_0F0F_0000, 64'h0000_0001_FFFF_FFFE};
        tbl[1] = '{16'h8001, 16'h7FFE, 0, 64'h8001_0000_7FFE_0000, 64'h0000_0001_FFFF_FFFE};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1, 64'h0,                   64'h0000_0001_FFFF_FFFE};
        tbl[3] = '{16'h1234, 16'hABCD, 0, 64'h1234_0000_ABCD_0000, 64'h0000_0001_FFFF_FFFE};

        repeat (3) tick();
        chk("ready_in_rst", 64'(rdy2), 0);
        rst = 0;
        tick();
        chk_reset_state();

        // Stereo frames from the vector table
        for (int i = 0; i < 4; i++) begin
            push({tbl[i].r, tbl[i].l});
            mute2 = tbl[i].mu;
            en2 = 1;
            capture(5, sw, lw);
            void'(mq.pop_front());
            chk("tbl_sda", sw, tbl[i].exp_sda);
            chk("tbl_lrclk", lw, tbl[i].exp_lr);
            wait_idle();
        end
        mute2 = 0;

        // Underrun: empty frames set it, a clear pulse drops it, set beats a coincident clear
        clr2 = 1; tick(); clr2 = 0;
        en2 = 1;
        play(2, 10, 0);
        chk("underrun_set", 64'(ur2), 1);
        clr2 = 1; tick(); clr2 = 0;
        chk("underrun_clr", 64'(ur2), 0);
        en2 = 1; clr2 = 1;
        tick();
        clr2 = 0;
        chk("underrun_set_wins", 64'(ur2), 1);
        play(1, 3, 0);
        clr2 = 1; tick(); clr2 = 0;

        // FIFO full: 17 back-to-back writes, 16 kept, first pop reopens ready
        for (int i = 0; i < 17; i++) push($urandom);
        chk("full_level", 64'(lvl2), 16);
        chk("full_ready", 64'(rdy2), 0);
        en2 = 1;
        tick();
        chk("pop_ready", 64'(rdy2), 1);
        chk("pop_level", 64'(lvl2), 15);
        play(17, 2, 0);
        clr2 = 1; tick(); clr2 = 0;

        // TDM: four 16-bit slots, frame sync on the last bit
        sel = 1;
        d4 = 64'h4444_3333_2222_1111; v4 = 1;
        tick();
        v4 = 0; en4 = 1;
        capture(5, sw, lw);
        chk("tdm_sda", sw, 64'h1111_2222_3333_4444);
        chk("tdm_lrclk", lw, 64'h1);
        wait_idle();
        chk("tdm_underrun", 64'(ur4), 0);
        sel = 0;

        // Mute with two frames queued, enable dropped at bit 20 of the second
        push(32'hDEAD_BEEF);
        push(32'h1357_9BDF);
        mute2 = 1; en2 = 1;
        play(2, 20, 1);
        chk("mute_underrun", 64'(ur2), 0);
        mute2 = 0;

        // Random bursts against the model, trailing empty frame each round
        for (int r = 0; r < 5; r++) begin
            k = $urandom_range(0, 3);
            mu = 1'($urandom_range(0, 1));
            for (int i = 0; i < k; i++) push($urandom);
            chk("rnd_level", 64'(lvl2), 64'(k));
            mute2 = mu; en2 = 1;
            play(k + 1, $urandom_range(1, 62), mu);
            chk("rnd_underrun", 64'(ur2), 1);
            clr2 = 1; tick(); clr2 = 0;
        end
        mute2 = 0;

        // Reset mid-frame with data queued
        push($urandom);
        push($urandom);
        en2 = 1;
        repeat (100) tick();
        rst = 1; en2 = 0;
        tick();
        chk("ready_in_rst2", 64'(rdy2), 0);
        repeat (2) tick();
        rst = 0;
        tick();
        mq.delete();
        chk_reset_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
